// File: rtl/priv_trap_ctrl_n.sv
// Machine-mode trap controller: pending/enable interrupt latch, exception/interrupt/mret arbitration, redirect FSM.
// Optional PRIV_IRQ_EDGE_EN: irq_set becomes 0->1 edge-triggered instead of level-sensitive.
module priv_trap_ctrl_n #(
  parameter int unsigned NUM_IRQ = 16,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic [NUM_IRQ-1:0] irq_clear,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               ie_wen,
  input  logic               ie_wdata,
  input  logic               exception,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    epc,
  input  logic               mret,
  input  logic               pipe_ack,
  input  logic [XLEN-1:0]    mtvec_base,
  input  logic               mtvec_vectored,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               intr,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mepc,
  output logic [NUM_IRQ-1:0] mip,
  output logic               ie
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRAP = 2'd1;
  localparam logic [1:0] S_RET  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] mip_q, mip_d;
  logic               ie_q, ie_d;
  logic               sie_q, sie_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic               intr_q, intr_d;
  logic               insert_q, insert_d;
  logic [XLEN-1:0]    priv_q, priv_d;

  logic [NUM_IRQ-1:0] set_eff;
  logic [NUM_IRQ-1:0] pend;
  logic [CAUSE_W-1:0] idx;
  logic [CAUSE_W-1:0] cause;
  logic               irq_ok;

`ifdef PRIV_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_q;

  always_ff @(posedge CLK) begin
    if (!nRST) irq_prev_q <= '0;
    else       irq_prev_q <= irq_set;
  end

  assign set_eff = irq_set & ~irq_prev_q;
`else
  assign set_eff = irq_set;
`endif

  assign pend   = mip_q & irq_en;
  assign irq_ok = ie_q && (pend != '0);

  // Lowest pending index wins: scan downward so the last hit is the smallest.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) idx = CAUSE_W'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      mip_q    <= '0;
      ie_q     <= 1'b0;
      sie_q    <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      intr_q   <= 1'b0;
      insert_q <= 1'b0;
      priv_q   <= '0;
    end else begin
      state_q  <= state_d;
      mip_q    <= mip_d;
      ie_q     <= ie_d;
      sie_q    <= sie_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      intr_q   <= intr_d;
      insert_q <= insert_d;
      priv_q   <= priv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mip_d    = (mip_q | set_eff) & ~irq_clear;
    ie_d     = ie_q;
    sie_d    = sie_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    intr_d   = intr_q;
    insert_d = insert_q;
    priv_d   = priv_q;
    cause    = exception ? exc_cause : idx;

    case (state_q)
      S_IDLE: begin
        if (exception || irq_ok) begin
          state_d  = S_TRAP;
          mepc_d   = epc;
          intr_d   = !exception;
          mcause_d = XLEN'(cause);
          mcause_d[XLEN-1] = !exception;
          sie_d    = ie_q;
          ie_d     = 1'b0;
          insert_d = 1'b1;
          priv_d   = (!exception && mtvec_vectored) ? mtvec_base + (XLEN'(idx) << 2)
                                                    : mtvec_base;
        end else begin
          if (ie_wen) ie_d = ie_wdata;
          if (mret) begin
            state_d  = S_RET;
            insert_d = 1'b1;
            priv_d   = mepc_q;
          end
        end
      end
      S_TRAP: begin
        if (pipe_ack) begin
          state_d  = S_IDLE;
          insert_d = 1'b0;
        end
      end
      S_RET: begin
        if (pipe_ack) begin
          state_d  = S_IDLE;
          insert_d = 1'b0;
          ie_d     = sie_q;
          sie_d    = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        insert_d = 1'b0;
      end
    endcase
  end

  assign insert_pc = insert_q;
  assign priv_pc   = priv_q;
  assign intr      = intr_q;
  assign mcause    = mcause_q;
  assign mepc      = mepc_q;
  assign mip       = mip_q;
  assign ie        = ie_q;

endmodule

// File: doc/priv_trap_ctrl_n.md
Name: priv_trap_ctrl_n

Overview:
- Parametrised successor to the fixed three-source machine-mode trap logic.
- Latches up to NUM_IRQ interrupt sources with per-channel enables and fixed priority, arbitrates them against synchronous exceptions, and drives the pipeline redirect through a trap/return FSM.
- Supports direct or vectored trap vectors and saves/restores the global interrupt enable around traps.
- Sits between the core interrupt sources, the CSR file and the pipeline control.

Parameters:
- NUM_IRQ, 16, number of interrupt channels; 1..2**CAUSE_W.
- XLEN, 32, datapath / PC width.
- CAUSE_W, 5, width of the cause code field.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- irq_set  in  NUM_IRQ  per-channel interrupt raise
- irq_clear  in  NUM_IRQ  per-channel interrupt clear
- irq_en  in  NUM_IRQ  per-channel enable (mie)
- ie_wen  in  1  CSR write strobe for global IE
- ie_wdata  in  1  CSR write data for global IE
- exception  in  1  synchronous exception from pipeline
- exc_cause  in  CAUSE_W  exception cause code
- epc  in  XLEN  PC of the faulting/interrupted instruction
- mret  in  1  return-from-trap request
- pipe_ack  in  1  pipeline has flushed and accepted the redirect
- mtvec_base  in  XLEN  trap base address, 4-byte aligned
- mtvec_vectored  in  1  0 = direct, 1 = vectored
- insert_pc  out  1  redirect request
- priv_pc  out  XLEN  redirect target
- intr  out  1  current trap is an interrupt
- mcause  out  XLEN  {intr, zero-fill, cause}
- mepc  out  XLEN  saved PC
- mip  out  NUM_IRQ  pending bits
- ie  out  1  global interrupt enable

Behaviour:
- Reset (nRST low at a CLK edge): mip=0, ie=0, saved IE=0, mepc=0, mcause=0, intr=0, insert_pc=0, priv_pc=0, state=IDLE. Asserting nRST low mid-trap aborts the trap the same cycle.
- Pending update, every cycle: mip_next = (mip | irq_set) & ~irq_clear. Clear wins when set and clear hit the same bit.
- Taking a trap does not clear mip.
- Global IE: ie_wen loads ie from ie_wdata in IDLE only; ignored in other states.
- Candidate: pend = mip & irq_en. The lowest set index wins. An interrupt is eligible when ie=1 and pend is non-zero.
- Arbitration: exception > interrupt > mret. Arbitration is evaluated only in IDLE.
- IDLE -> TRAP on exception, or on an eligible interrupt. Registered at the edge:
  - mepc <= epc
  - mcause <= {exception?0:1, 0…, cause}, where cause is exc_cause or the winning index
  - intr set accordingly
  - saved IE <= ie; ie <= 0
- TRAP:
  - insert_pc=1.
  - priv_pc = mtvec_base, or mtvec_base + (index << 2) when vectored and intr.
  - Exceptions always use the base address.
  - Hold insert_pc and priv_pc stable until pipe_ack. On pipe_ack -> IDLE, and insert_pc drops the next cycle.
  - Latency: insert_pc asserts 1 cycle after the request.
- IDLE -> RET on mret with no exception/interrupt that cycle.
- RET:
  - insert_pc=1, priv_pc=mepc.
  - On pipe_ack: ie <= saved IE, saved IE <= 1, -> IDLE.
- exception, mret and new interrupts arriving in TRAP/RET are ignored; the pipeline re-presents them. mip still accumulates.
- pipe_ack received in IDLE has no effect.
- mcause is zero-extended from CAUSE_W+1 bits with the interrupt flag at bit XLEN-1.
- Vector addition wraps modulo 2**XLEN.

Optional Feature:
- PRIV_IRQ_EDGE_EN defined: irq_set is edge-detected with a per-channel registered previous value, reset to 0. Only the 0->1 transition sets mip; a held-high input sets the bit once.
- Undefined: irq_set is level-sensitive as above, and no extra registers are built.

Test Plan:
- Reset, then set ie=1 and irq_en=16'h0030; raise irq_set[5] and irq_set[4] in the same cycle, direct mode, base 32'h8000_0000 -> next cycle insert_pc=1, priv_pc=32'h8000_0000, mcause=32'h8000_0004, ie=0; hold until pipe_ack.
- Vectored mode, base 32'h8000_0100, irq 9 pending and enabled -> priv_pc=32'h8000_0124, intr=1.
- exception (cause 2) and an eligible irq 3 in the same cycle -> mcause=32'h0000_0002, priv_pc=base even in vectored mode, mepc=epc.
- Trap taken with ie=1, then mret, then pipe_ack -> priv_pc=mepc during RET; ie=1 afterwards.
- irq_set[7] and irq_clear[7] in the same cycle -> mip[7]=0. Set alone, then clear -> bit rises, then falls one cycle after the clear.
- nRST low while in TRAP with insert_pc=1 -> next edge: insert_pc=0, state IDLE, mip=0. With PRIV_IRQ_EDGE_EN, holding irq_set[2] high while clearing it once -> mip[2] stays 0.
